// File: rtl/drive_pkg.sv
// Shared widths, command limits and controller state type for drive_ramp.
package drive_pkg;
    localparam int CMD_W = 11;
    localparam logic signed [CMD_W-1:0] CMD_MAX = 11'sd1023;
    localparam logic signed [CMD_W-1:0] CMD_MIN = -11'sd1023;

    typedef enum logic [1:0] {IDLE, RAMP, HOLD, STOP} ramp_state_e;
endpackage

// File: rtl/ramp_chan.sv
// One wheel channel: clamped target register, bounded-rate stepper and zero-crossing clamp.
// DRIVE_RAMP_ZERO_DWELL_EN adds a hold at 0 for DWELL_TICKS ticks after a sign reversal.
module ramp_chan
    import drive_pkg::*;
#(
    parameter int STEP      = 8,
    parameter int STOP_STEP = 32
`ifdef DRIVE_RAMP_ZERO_DWELL_EN
    ,
    parameter int DWELL_TICKS = 3
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [CMD_W-1:0] cmd,
    input  logic                    load,
    input  logic                    stop,
    input  logic                    step_en,
    input  logic                    fast,
    output logic signed [CMD_W-1:0] value,
    output logic                    at_tgt,
    output logic                    cmd_differs
);
    logic signed [CMD_W-1:0] cmd_clamped;
    logic signed [CMD_W-1:0] tgt;
    logic signed [CMD_W-1:0] next_val;
    logic signed [CMD_W:0]   diff;
    logic signed [CMD_W:0]   stepped;
    logic        [CMD_W:0]   diff_mag;
    logic        [CMD_W:0]   step_sz;
    logic                    hold;

    // -1024 has no positive counterpart in 10 bits of magnitude
    assign cmd_clamped = (cmd < CMD_MIN) ? CMD_MIN : ((cmd > CMD_MAX) ? CMD_MAX : cmd);
    assign cmd_differs = (cmd_clamped != value);
    assign at_tgt      = (tgt == value);
    assign step_sz     = fast ? (CMD_W+1)'(STOP_STEP) : (CMD_W+1)'(STEP);
    assign diff        = {tgt[CMD_W-1], tgt} - {value[CMD_W-1], value};
    assign diff_mag    = diff[CMD_W] ? (CMD_W+1)'(-diff) : (CMD_W+1)'(diff);

    always_comb begin
        if (diff_mag <= step_sz) begin
            stepped = {tgt[CMD_W-1], tgt};
        end else if (diff[CMD_W]) begin
            stepped = {value[CMD_W-1], value} - step_sz;
        end else begin
            stepped = {value[CMD_W-1], value} + step_sz;
        end
        next_val = stepped[CMD_W-1:0];
        // a sign reversal always passes through exactly 0
        if (value != '0 && stepped != '0 && stepped[CMD_W] != value[CMD_W-1]) begin
            next_val = '0;
        end
    end

`ifdef DRIVE_RAMP_ZERO_DWELL_EN
    localparam int DW = (DWELL_TICKS > 0) ? $clog2(DWELL_TICKS + 1) : 1;
    logic [DW-1:0] dwell;
    logic          reversal;

    assign reversal = (value != '0) && (next_val == '0) && (tgt != '0) &&
                      (tgt[CMD_W-1] != value[CMD_W-1]);
    assign hold     = (dwell != '0);

    always_ff @(posedge clk) begin
        if (rst || stop) begin
            dwell <= '0;
        end else if (step_en) begin
            if (hold) begin
                dwell <= dwell - 1'b1;
            end else if (reversal) begin
                dwell <= DW'(DWELL_TICKS);
            end
        end
    end
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst || stop) begin
            tgt <= '0;
        end else if (load) begin
            tgt <= cmd_clamped;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (step_en && !hold) begin
            value <= next_val;
        end
    end
endmodule

// File: rtl/drive_ramp.sv
// Slew-rate limiter for left/right wheel commands: shared ramp prescaler and sequencing FSM.
// DRIVE_RAMP_ZERO_DWELL_EN enables the zero-crossing dwell (DWELL_TICKS exists only then).
module drive_ramp
    import drive_pkg::*;
#(
    parameter int RAMP_DIV  = 4096,
    parameter int STEP      = 8,
    parameter int STOP_STEP = 32
`ifdef DRIVE_RAMP_ZERO_DWELL_EN
    ,
    parameter int DWELL_TICKS = 3
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [CMD_W-1:0] lft_cmd,
    input  logic signed [CMD_W-1:0] rht_cmd,
    input  logic                    cmd_vld,
    input  logic                    estop,
    output logic signed [CMD_W-1:0] lft,
    output logic signed [CMD_W-1:0] rht,
    output logic                    settled,
    output logic                    busy
);
    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic          load;
    logic          step_en;
    logic          fast;
    logic          lft_at, rht_at;
    logic          lft_diff, rht_diff;
    ramp_state_e   state;

    assign tick    = (pre_cnt == PW'(RAMP_DIV - 1));
    assign load    = cmd_vld && !estop && (state != STOP);
    assign step_en = tick && (state == RAMP || state == STOP);
    assign fast    = (state == STOP);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    ramp_chan #(
        .STEP(STEP), .STOP_STEP(STOP_STEP)
`ifdef DRIVE_RAMP_ZERO_DWELL_EN
        , .DWELL_TICKS(DWELL_TICKS)
`endif
    ) u_lft (
        .clk(clk), .rst(rst), .cmd(lft_cmd), .load(load), .stop(estop),
        .step_en(step_en), .fast(fast), .value(lft), .at_tgt(lft_at), .cmd_differs(lft_diff)
    );

    ramp_chan #(
        .STEP(STEP), .STOP_STEP(STOP_STEP)
`ifdef DRIVE_RAMP_ZERO_DWELL_EN
        , .DWELL_TICKS(DWELL_TICKS)
`endif
    ) u_rht (
        .clk(clk), .rst(rst), .cmd(rht_cmd), .load(load), .stop(estop),
        .step_en(step_en), .fast(fast), .value(rht), .at_tgt(rht_at), .cmd_differs(rht_diff)
    );

    // HOLD is entered one cycle after the last step, once the registered outputs match
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            settled <= 1'b0;
            busy    <= 1'b0;
        end else if (estop) begin
            state   <= STOP;
            settled <= 1'b0;
            busy    <= 1'b1;
        end else begin
            unique case (state)
                IDLE: if (load) begin
                    state <= RAMP;
                    busy  <= 1'b1;
                end
                RAMP: if (!load && lft_at && rht_at) begin
                    state   <= HOLD;
                    busy    <= 1'b0;
                    settled <= 1'b1;
                end
                HOLD: if (load && (lft_diff || rht_diff)) begin
                    state   <= RAMP;
                    busy    <= 1'b1;
                    settled <= 1'b0;
                end
                STOP: if (lft == '0 && rht == '0) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_drive_ramp.sv
// Bench for drive_ramp: tick-level arithmetic reference model feeding an output-change scoreboard.
module tb_drive_ramp;
    localparam int DIV       = 4;
    localparam int STEP      = 8;
    localparam int STOP_STEP = 32;
`ifdef DRIVE_RAMP_ZERO_DWELL_EN
    localparam int DWELL     = 3;
    localparam int REV_TICKS = 13;
`else
    localparam int REV_TICKS = 10;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_vld;
    logic               estop;
    logic signed [10:0] lft_cmd, rht_cmd;
    logic signed [10:0] lft, rht;
    logic               settled, busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int l;
        int r;
    } pair_t;
    pair_t sbq[$];

    int m_l = 0, m_r = 0, t_l = 0, t_r = 0, cnt = 0, dw_l = 0, dw_r = 0;
    int tick_total = 0, pl_push = 0, pr_push = 0, tk0 = 0;
    bit m_stop = 0;
    bit mon_en = 0;
    int p_l = 0, p_r = 0;

    drive_ramp #(.RAMP_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .lft_cmd(lft_cmd), .rht_cmd(rht_cmd), .cmd_vld(cmd_vld),
        .estop(estop), .lft(lft), .rht(rht), .settled(settled), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int clampv(input int c);
        return (c < -1023) ? -1023 : c;
    endfunction

    task automatic step_chan(input int cur, input int tgt, input int s, inout int dw, output int nxt);
        int d, ad;
        if (dw > 0) begin
            dw--;
            nxt = cur;
        end else begin
            d  = tgt - cur;
            ad = (d < 0) ? -d : d;
            if (ad <= s) nxt = tgt;
            else nxt = cur + ((d > 0) ? s : -s);
            if ((cur > 0 && nxt < 0) || (cur < 0 && nxt > 0)) nxt = 0;
`ifdef DRIVE_RAMP_ZERO_DWELL_EN
            if (cur != 0 && nxt == 0 && ((cur > 0 && tgt < 0) || (cur < 0 && tgt > 0))) dw = DWELL;
`endif
        end
    endtask

    // Reference model: every tick moves each wheel toward its target; stepping is a no-op once settled
    always @(posedge clk) begin
        int nl, nr, s;
        bit tk, nstop;
        if (rst) begin
            m_l = 0; m_r = 0; t_l = 0; t_r = 0; cnt = 0; dw_l = 0; dw_r = 0; m_stop = 0;
        end else begin
            tk  = (cnt == DIV - 1);
            cnt = tk ? 0 : cnt + 1;
            nl  = m_l;
            nr  = m_r;
            if (tk) begin
                tick_total++;
                s = m_stop ? STOP_STEP : STEP;
                step_chan(m_l, t_l, s, dw_l, nl);
                step_chan(m_r, t_r, s, dw_r, nr);
            end
            nstop = m_stop;
            if (estop) begin
                nstop = 1; t_l = 0; t_r = 0; dw_l = 0; dw_r = 0;
            end else if (m_stop) begin
                if (m_l == 0 && m_r == 0) nstop = 0;
            end else if (cmd_vld) begin
                t_l = clampv(int'(lft_cmd));
                t_r = clampv(int'(rht_cmd));
            end
            m_l = nl; m_r = nr; m_stop = nstop;
        end
        if (m_l != pl_push || m_r != pr_push) begin
            sbq.push_back('{m_l, m_r});
            pl_push = m_l;
            pr_push = m_r;
        end
    end

    always @(negedge clk) begin
        pair_t e;
        if (mon_en) begin
            if (int'(lft) != p_l || int'(rht) != p_r) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got lft=%0d rht=%0d, expected no change", lft, rht);
                end else begin
                    e = sbq.pop_front();
                    if (e.l != int'(lft) || e.r != int'(rht)) begin
                        bad++;
                        $display("FAIL sb_value: got lft=%0d rht=%0d, expected lft=%0d rht=%0d",
                                 lft, rht, e.l, e.r);
                    end
                end
                p_l = int'(lft);
                p_r = int'(rht);
            end else if (sbq.size() != 0) begin
                total++;
                bad++;
                e = sbq.pop_front();
                $display("FAIL sb_missing: got lft=%0d rht=%0d, expected lft=%0d rht=%0d",
                         lft, rht, e.l, e.r);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic issue(input int l, input int r);
        lft_cmd = 11'(l);
        rht_cmd = 11'(r);
        cmd_vld = 1'b1;
        @(negedge clk);
        cmd_vld = 1'b0;
        tk0 = tick_total;
    endtask

    task automatic wait_settled(input string nm, input int max_cyc, output int ticks);
        bit ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            if (settled) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk(nm, int'(ok), 1);
        ticks = tick_total - tk0;
    endtask

    task automatic wait_lft(input string nm, input int v, input int max_cyc);
        bit ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            if (int'(lft) == v) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk(nm, int'(ok), 1);
    endtask

    initial begin
        int tks;
        rst = 1'b1; cmd_vld = 1'b0; estop = 1'b0; lft_cmd = '0; rht_cmd = '0;
        repeat (3) @(negedge clk);
        chk("rst_lft", int'(lft), 0);
        chk("rst_rht", int'(rht), 0);
        chk("rst_settled", int'(settled), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        p_l = int'(lft); p_r = int'(rht);
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        issue(100, -50);
        chk("ramp_busy", int'(busy), 1);
        wait_settled("settle_100", 200, tks);
        chk("ticks_100", tks, 13);
        chk("final_lft_100", int'(lft), 100);
        chk("final_rht_m50", int'(rht), -50);
        chk("hold_busy", int'(busy), 0);

        issue(100, -50);
        for (int i = 0; i < 4; i++) begin
            chk("same_cmd_settled", int'(settled), 1);
            chk("same_cmd_busy", int'(busy), 0);
            @(negedge clk);
        end

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        issue(-1024, 0);
        wait_settled("settle_clamp", 700, tks);
        chk("ticks_clamp", tks, 128);
        chk("clamp_lft", int'(lft), -1023);

        issue(40, 0);
        wait_settled("settle_40", 1200, tks);
        issue(-40, 0);
        wait_settled("settle_rev", 200, tks);
        chk("ticks_rev", tks, REV_TICKS);
        chk("rev_lft", int'(lft), -40);

        issue(200, 0);
        wait_lft("reach_96", 96, 400);
        estop = 1'b1; cmd_vld = 1'b1; lft_cmd = 11'sd500; rht_cmd = 11'sd300;
        @(negedge clk);
        cmd_vld = 1'b0;
        chk("stop_busy", int'(busy), 1);
        chk("stop_settled", int'(settled), 0);
        wait_lft("stop_zero", 0, 100);
        repeat (6) @(negedge clk);
        chk("stop_hold_lft", int'(lft), 0);
        chk("stop_hold_rht", int'(rht), 0);
        chk("stop_hold_busy", int'(busy), 1);
        estop = 1'b0;
        @(negedge clk);
        chk("stop_exit_busy", int'(busy), 0);
        chk("stop_exit_settled", int'(settled), 0);

        issue(200, 0);
        chk("restart_busy", int'(busy), 1);
        wait_lft("reach_48", 48, 200);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_lft", int'(lft), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_settled", int'(settled), 0);
        issue(16, -16);
        wait_settled("settle_after_rst", 200, tks);
        chk("after_rst_lft", int'(lft), 16);
        chk("after_rst_rht", int'(rht), -16);

        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            case ($urandom_range(0, 9))
                0: begin
                    estop = 1'b1;
                    if ($urandom_range(0, 1) == 1) begin
                        lft_cmd = 11'($urandom);
                        cmd_vld = 1'b1;
                    end
                    repeat ($urandom_range(1, 25)) begin
                        @(negedge clk);
                        cmd_vld = 1'b0;
                    end
                    estop = 1'b0;
                end
                1: issue(-1024, int'($urandom_range(0, 2046)) - 1023);
                default: issue(int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024);
            endcase
        end

        begin
            bit quiet = 0;
            for (int i = 0; i < 3000; i++) begin
                @(negedge clk);
                if (settled || !busy) begin
                    quiet = 1;
                    break;
                end
            end
            chk("final_quiet", int'(quiet), 1);
        end
        repeat (2) @(negedge clk);
        chk("sb_drain", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
